// File: rtl/rv_imem_ctrl_pkg.sv
// Shared types and constants for the rv_cpu instruction memory controller.
package rv_imem_ctrl_pkg;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FILL,
    LOAD,
    SERVE
  } t_imem_state;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } t_imem_rsp;

endpackage

// File: rtl/rv_imem_rsp_pipe.sv
// LATENCY-deep response shift pipeline with flush; the output data holds the
// last delivered word whenever no response is presented.
module rv_imem_rsp_pipe
  import rv_imem_ctrl_pkg::*;
#(
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = IMEM_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic        in_err_i,
  input  logic [31:0] in_data_i,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_data_o
);

  t_imem_rsp   st_in;
  t_imem_rsp   st_q [LATENCY];
  logic [31:0] hold_q;

  always_comb begin
    st_in       = '0;
    st_in.valid = in_valid_i;
    st_in.err   = in_err_i;
    st_in.data  = in_data_i;
  end

  // stage 1 captures the array read at the accept edge; later stages shift
  always_ff @(posedge clk) begin
    st_q[0] <= st_in;
    for (int i = 1; i < LATENCY; i++) begin
      st_q[i] <= st_q[i-1];
    end
    if (!rst || flush_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        st_q[i].valid <= 1'b0;
      end
    end
  end

  // output boundary: flush masks the response leaving this cycle as well
  assign rsp_valid_o = st_q[LATENCY-1].valid && !flush_i;
  assign rsp_err_o   = rsp_valid_o && st_q[LATENCY-1].err;
  assign rsp_data_o  = rsp_valid_o ? st_q[LATENCY-1].data : hold_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= NOP_WORD;
    end else if (rsp_valid_o) begin
      hold_q <= st_q[LATENCY-1].data;
    end
  end

endmodule

// File: rtl/rv_imem_ctrl.sv
// Instruction memory for rv_cpu: NOP auto-fill, serial load port, pipelined fetch.
// Define RV_IMEM_PARITY_EN to store a per-word even-parity bit and add par_inject.
module rv_imem_ctrl
  import rv_imem_ctrl_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = IMEM_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
`ifdef RV_IMEM_PARITY_EN
  input  logic        par_inject,
`endif
  output logic        fill_done
);

  localparam int AW = $clog2(DEPTH);
`ifdef RV_IMEM_PARITY_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif

  // upper address bits only feed the range check, never the index
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  t_imem_state   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          fill_done_q, fill_done_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [MW-1:0] mem_wdata;
  logic [MW-1:0] mem_q [DEPTH];

  logic [MW-1:0] fill_word, load_word;
  logic [AW-1:0] rd_idx;
  logic [MW-1:0] rd_word;
  logic          rd_err;
  logic [31:0]   rd_data;
  logic          req_acc;

`ifdef RV_IMEM_PARITY_EN
  assign fill_word = {^NOP_WORD, NOP_WORD};
  assign load_word = {(^ld_data) ^ par_inject, ld_data};
`else
  assign fill_word = NOP_WORD;
  assign load_word = ld_data;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    fill_done_d = fill_done_q;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = fill_word;
    req_ready   = 1'b0;
    case (state_q)
      FILL: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          fill_done_d = 1'b1;
          state_d     = ld_en ? LOAD : SERVE;
        end
      end
      LOAD: begin
        if (ld_valid && !addr_bad(ld_addr)) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr[AW+1:2];
          mem_wdata = load_word;
        end
        if (!ld_en) begin
          state_d = SERVE;
        end
      end
      SERVE: begin
        // ld_en gates ready combinationally so no fetch slips in as load starts
        req_ready = !ld_en;
        if (ld_en) begin
          state_d = LOAD;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      ptr_q       <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      fill_done_q <= fill_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign req_acc = req_valid && req_ready;
  assign rd_idx  = req_addr[AW+1:2];
  assign rd_word = mem_q[rd_idx];

  // address errors return NOP; parity errors return the raw stored word
  always_comb begin
    rd_err  = 1'b0;
    rd_data = rd_word[31:0];
    if (addr_bad(req_addr)) begin
      rd_err  = 1'b1;
      rd_data = NOP_WORD;
    end
`ifdef RV_IMEM_PARITY_EN
    else if (^rd_word) begin
      rd_err = 1'b1;
    end
`endif
  end

  rv_imem_rsp_pipe #(
    .LATENCY  (LATENCY),
    .NOP_WORD (NOP_WORD)
  ) u_rsp_pipe (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (req_acc),
    .in_err_i    (rd_err),
    .in_data_i   (rd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_err_o   (rsp_err),
    .rsp_data_o  (rsp_data)
  );

  assign fill_done = fill_done_q;

endmodule

// File: doc/rv_imem_ctrl.md
Name: rv_imem_ctrl

Overview:
Parametrised instruction memory for the rv_cpu pipeline. It adds a synchronous, pipelined read path with configurable latency and a request/response handshake, so IF can stall. It also adds a flush to kill in-flight fetches on redirect, and a serial load port that replaces hierarchical preloading. After reset it auto-fills the array with NOPs before serving fetches.

Parameters:
DEPTH, 256, number of 32-bit words (power of 2, ≥4)
LATENCY, 1, cycles from accepted request to response (legal 1..4)
NOP_WORD, 32'h00000013, fill value and error-response data

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req_valid  in  1  fetch request
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  32  byte address of fetch
flush  in  1  kill all in-flight fetches (pipeline redirect)
rsp_valid  out  1  response strobe; no backpressure
rsp_data  out  32  instruction word
rsp_err  out  1  request was misaligned or out of range
ld_en  in  1  load mode; blocks fetches
ld_valid  in  1  write one word
ld_addr  in  32  byte address of load word
ld_data  in  32  load word
fill_done  out  1  high once post-reset NOP fill completes

Behaviour:
- Reset (rst==0 at posedge): state=FILL, fill pointer=0, all in-flight valid bits cleared. Outputs: req_ready=0, rsp_valid=0, rsp_data=NOP_WORD, rsp_err=0, fill_done=0. A reset mid-operation drops every pending response and restarts FILL.
- FSM states: FILL, LOAD, SERVE.
  - FILL: writes NOP_WORD to word[ptr] each cycle, ptr++. After word DEPTH-1 is written, goes to SERVE (ld_en==0) or LOAD (ld_en==1). Sets fill_done=1, which stays 1 until the next reset. The fill takes exactly DEPTH cycles. ld_valid is ignored in FILL.
  - LOAD: req_ready=0. On ld_valid, writes ld_data to word[ld_addr[log2(DEPTH)+1:2]]. Out-of-range or misaligned ld_addr is silently dropped. When ld_en falls, goes to SERVE on the next cycle.
  - SERVE: req_ready=1 when ld_en==0. When ld_en rises, req_ready=0 the same cycle (combinational) and the FSM goes to LOAD. Responses already in flight still complete.
- Read pipeline:
  - One request accepted per cycle; responses are returned in order exactly LATENCY cycles after acceptance.
  - The array read occurs at the accept edge. Stages 2..LATENCY are a register shift of {valid, data, err}.
- Error: if req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH, the response carries rsp_err=1 and rsp_data=NOP_WORD. The response is still delivered with normal latency.
- Flush: in the cycle flush=1, every in-flight valid bit is cleared and rsp_valid is forced 0. A request accepted in that same cycle is also killed. Requests accepted in the next cycle proceed normally.
- When rsp_valid=0, rsp_data holds its last value.
- Width rules: only req_addr[log2(DEPTH)+1:2] indexes the array. The upper bits are used solely for the range check.

Optional Feature:
RV_IMEM_PARITY_EN:
- Defined: each word stores an extra even-parity bit, written in FILL and LOAD. On read, a parity mismatch sets rsp_err=1; rsp_data is the raw stored word, not NOP.
- Adds an input port par_inject (1 bit). While high, LOAD writes inverted parity, for test use.
- Undefined: no parity storage, no par_inject port; rsp_err reflects only address errors.

Decomposition:
- pkg: IMEM_NOP constant; t_imem_state enum {FILL, LOAD, SERVE}; t_imem_rsp struct {valid, err, data}.
- Sub-module: rv_imem_rsp_pipe — the LATENCY-deep shift pipeline of t_imem_rsp with flush clear. The array and FSM stay in the top.

Test Plan:
- Release reset, DEPTH=256 → fill_done rises exactly 256 cycles after release; req_ready=0 until then. A fetch of 0x40 then returns 0x00000013, rsp_err=0.
- ld_en=1; load 0x00A00093@0x0 and 0x01400113@0x4; ld_en=0; back-to-back fetch 0x0, 0x4 with LATENCY=3 → rsp_valid on cycles +3 and +4, data in order.
- Fetch 0x2 → rsp_err=1, data 0x00000013. Fetch 0x400 (DEPTH=256) → rsp_err=1.
- LATENCY=3: issue 3 fetches; flush on the third accept cycle → no rsp_valid for any of them; a fetch issued the next cycle responds normally.
- Drop rst for one cycle with 2 fetches in flight → no rsp_valid afterward; FILL restarts and overwrites loaded words with NOP.
- RV_IMEM_PARITY_EN: load 0xDEADBEEF@0x8 with par_inject=1 → fetch 0x8 gives rsp_err=1, rsp_data=0xDEADBEEF.
